// File: rtl/aes_pkg.sv
// Shared types and helpers for the sequential AES key-schedule engine:
// key-size derivation, FSM state encoding and the Rcon xtime step.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_e;

    function automatic bit key_bits_ok(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

    function automatic int nk_of(input int kb);
        return kb / 32;
    endfunction

    function automatic int nr_of(input int kb);
        return nk_of(kb) + 6;
    endfunction

    function automatic int nw_of(input int kb);
        return 4 * (nr_of(kb) + 1);
    endfunction

    // GF(2^8) multiply-by-two, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_s4.sv
// Four parallel AES forward S-boxes (SubWord), purely combinational.
module aes_key_expand_seq_s4
    import aes_pkg::*;
(
    input  word_t din,
    output word_t dout
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per cycle into a
// word buffer, with a registered round-key read port.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                busy,
    output logic                done,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    localparam int IW = $clog2(NW);

    localparam logic [IW-1:0] NK_W    = IW'(NK);
    localparam logic [IW-1:0] LAST_W  = IW'(NW - 1);
    localparam logic [2:0]    PH_LAST = 3'(NK - 1);
    localparam logic [3:0]    NR_W    = 4'(NR);
    localparam bit            HAS_MID = (NK == 8);

    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_e       state, state_nxt;
    logic            accept;
    word_t           w_buf [NW];
    logic [IW-1:0]   idx;
    logic [2:0]      phase;
    logic [7:0]      rcon;
    word_t           w_prev, w_back, s4_in, s4_out, t_word, w_new;
    logic [IW-1:0]   rd_base;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                accept    = key_valid;
                if (key_valid) state_nxt = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (idx == LAST_W) state_nxt = DONE;
            end
            DONE: begin
                key_ready = 1'b1;
                done      = 1'b1;
                accept    = key_valid;
                if (key_valid) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign w_prev = w_buf[idx - 1'b1];
    assign w_back = w_buf[idx - NK_W];

    // RotWord only on the Rcon step; the AES-256 mid-step feeds S4 unrotated
    assign s4_in = (phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_key_expand_seq_s4 u_s4 (
        .din  (s4_in),
        .dout (s4_out)
    );

    always_comb begin
        t_word = w_prev;
        if (phase == 3'd0)                 t_word = s4_out ^ {rcon, 24'h0};
        else if (HAS_MID && phase == 3'd4) t_word = s4_out;
    end

    assign w_new = w_back ^ t_word;

    // phase tracks idx mod NK without a divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
        end else if (accept) begin
            idx   <= NK_W;
            phase <= '0;
            rcon  <= 8'h01;
        end else if (state == EXPAND) begin
            idx   <= idx + 1'b1;
            phase <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) rcon <= xtime(rcon);
        end
    end

    // Buffer is never cleared; writes are suppressed on a reset edge
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                for (int k = 0; k < NK; k++)
                    w_buf[IW'(k)] <= key_in[KEY_BITS-1-32*k -: 32];
            end else if (state == EXPAND) begin
                w_buf[idx] <= w_new;
            end
        end
    end

    assign rd_base = IW'({rd_round, 2'b00});

    always_ff @(posedge clk) begin
        if (!rst_n)               rd_key <= '0;
        else if (rd_round > NR_W) rd_key <= '0;
        else rd_key <= {w_buf[rd_base], w_buf[rd_base + 1'b1],
                        w_buf[rd_base + 2'd2], w_buf[rd_base + 2'd3]};
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench: one DUT per key size, scoreboard of expected round keys.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] a_key = '0;
    logic         a_valid = 1'b0, a_ready, a_busy, a_done;
    logic [3:0]   a_rd_round = '0;
    logic [127:0] a_rd_key;

    logic [191:0] b_key = '0;
    logic         b_valid = 1'b0, b_ready, b_busy, b_done;
    logic [3:0]   b_rd_round = '0;
    logic [127:0] b_rd_key;

    logic [255:0] c_key = '0;
    logic         c_valid = 1'b0, c_ready, c_busy, c_done;
    logic [3:0]   c_rd_round = '0;
    logic [127:0] c_rd_key;

    aes_key_expand_seq #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(a_key), .key_valid(a_valid),
        .key_ready(a_ready), .busy(a_busy), .done(a_done),
        .rd_round(a_rd_round), .rd_key(a_rd_key));

    aes_key_expand_seq #(.KEY_BITS(192)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(b_key), .key_valid(b_valid),
        .key_ready(b_ready), .busy(b_busy), .done(b_done),
        .rd_round(b_rd_round), .rd_key(b_rd_key));

    aes_key_expand_seq #(.KEY_BITS(256)) dut_c (
        .clk(clk), .rst_n(rst_n), .key_in(c_key), .key_valid(c_valid),
        .key_ready(c_ready), .busy(c_busy), .done(c_done),
        .rd_round(c_rd_round), .rd_key(c_rd_key));

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KJUNK  = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int           inst;
        logic [3:0]   rnd;
        logic [127:0] exp;
        string        name;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [3:0] r, input logic [127:0] e, input string n);
        sb_t s;
        s.inst = inst; s.rnd = r; s.exp = e; s.name = n;
        sb_q.push_back(s);
    endtask

    // read one round key through the registered port (value only, no compare)
    task automatic rd(input int inst, input logic [3:0] r, output logic [127:0] v);
        case (inst)
            0:       a_rd_round = r;
            1:       b_rd_round = r;
            default: c_rd_round = r;
        endcase
        tick();
        case (inst)
            0:       v = a_rd_key;
            1:       v = b_rd_key;
            default: v = c_rd_key;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (a_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
        checks++; if (a_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
        checks++; if (a_rd_key !== '0)    begin errors++; $display("FAIL reset_rd_key: got %h expected 0", a_rd_key); end
        checks++; if (b_ready !== 1'b1 || c_ready !== 1'b1)
            begin errors++; $display("FAIL reset_ready_bc: got %b%b expected 11", b_ready, c_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_aes128();
        int cnt;
        logic [127:0] v;
        sb_t e;
        a_key = K128; a_valid = 1'b1;
        push(0, 4'd0,  K128, "a128_r0");
        push(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "a128_r1");
        push(0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "a128_r2");
        push(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_r10");
        tick();
        a_valid = 1'b0;
        checks++; if (a_busy !== 1'b1 || a_ready !== 1'b0)
            begin errors++; $display("FAIL a128_busy: got busy=%b ready=%b expected 1 0", a_busy, a_ready); end
        cnt = 0;
        while (a_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++; if (cnt !== 40) begin errors++; $display("FAIL a128_latency: got %0d expected 40", cnt); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd(e.inst, e.rnd, v);
            checks++; if (v !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, v, e.exp); end
        end
    endtask

    task automatic test_aes192();
        int cnt;
        logic [127:0] v;
        sb_t e;
        b_key = K192; b_valid = 1'b1;
        push(1, 4'd0,  K192[191:64], "a192_r0");
        push(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "a192_r12");
        tick();
        b_valid = 1'b0;
        cnt = 0;
        while (b_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++; if (cnt !== 46) begin errors++; $display("FAIL a192_latency: got %0d expected 46", cnt); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd(e.inst, e.rnd, v);
            checks++; if (v !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, v, e.exp); end
        end
    endtask

    task automatic test_aes256();
        int cnt;
        logic [127:0] v;
        sb_t e;
        c_key = K256; c_valid = 1'b1;
        push(2, 4'd0,  K256[255:128], "a256_r0");
        push(2, 4'd1,  K256[127:0],   "a256_r1");
        push(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "a256_r14");
        tick();
        c_valid = 1'b0;
        cnt = 0;
        while (c_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++; if (cnt !== 52) begin errors++; $display("FAIL a256_latency: got %0d expected 52", cnt); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd(e.inst, e.rnd, v);
            checks++; if (v !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, v, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [127:0] v;
        sb_t e;
        checks++; if (a_done !== 1'b1 || a_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_pre_done: got done=%b ready=%b expected 1 1", a_done, a_ready); end
        a_key = K128B; a_valid = 1'b1;
        push(0, 4'd0,  K128B, "b2b_r0");
        push(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "b2b_r10");
        push(0, 4'd15, 128'h0, "b2b_oor");
        tick();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", a_done); end
        a_key = KJUNK;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", a_ready); end
            tick(); cnt++;
        end
        a_valid = 1'b0;
        while (a_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++; if (cnt !== 40) begin errors++; $display("FAIL b2b_latency: got %0d expected 40", cnt); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd(e.inst, e.rnd, v);
            checks++; if (v !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, v, e.exp); end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic [127:0] v;
        sb_t e;
        a_key = K128; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_pre: got %b expected 1", a_busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", a_busy); end
        checks++; if (a_done !== 1'b0)  begin errors++; $display("FAIL rst_mid_done: got %b expected 0", a_done); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", a_ready); end
        checks++; if (a_rd_key !== '0)  begin errors++; $display("FAIL rst_mid_rd_key: got %h expected 0", a_rd_key); end
        rst_n = 1'b1;
        tick();
        checks++; if (a_done !== 1'b0 || a_busy !== 1'b0)
            begin errors++; $display("FAIL rst_mid_idle: got done=%b busy=%b expected 0 0", a_done, a_busy); end
        a_key = K128; a_valid = 1'b1;
        push(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "rst_r1");
        push(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rst_r10");
        tick();
        a_valid = 1'b0;
        cnt = 0;
        while (a_done !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++; if (cnt !== 40) begin errors++; $display("FAIL rst_latency: got %0d expected 40", cnt); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd(e.inst, e.rnd, v);
            checks++; if (v !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, v, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
